protocol_request_decoder: RTL
=============================

# protocol_request_decoder

Synthesizable receive-side parser for the adapter command protocol. Takes the byte stream delivered by the ISO/IEC 14443A receive path, validates the 4-byte little-endian magic, decodes the command byte and argument bytes, and presents one decoded request per frame to the command handler. Malformed frames are dropped and reported with an error code.

## Interface
- `MAGIC`, default `protocol_pkg::PROTOCOL_MAGIC`: expected 32-bit frame magic.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_data` input, 8 bits: received byte.
- `in_valid` input, 1 bit: `in_data` valid this cycle. No backpressure; a byte is accepted on every cycle where `in_valid` is 1.
- `in_last` input, 1 bit: final byte of frame. Qualified by `in_valid`.
- `in_error` input, 1 bit: frame error from lower layer, such as a CRC or parity failure. Sampled with the `in_last` beat.
- `req_valid` output, 1 bit: one-cycle pulse when a valid request has been decoded.
- `req_cmd` output, 8 bits: command code, one of the `protocol_pkg` `Command_*` values.
- `req_sync` output, 16 bits: sync field for SET_SIGNAL and AUTO_READ.
- `req_mask` output, 8 bits: SET_SIGNAL mask.
- `req_value` output, 8 bits: SET_SIGNAL value.
- `req_timing1` output, 25 bits: AUTO_READ timing1.
- `req_timing2` output, 25 bits: AUTO_READ timing2.
- `err_valid` output, 1 bit: one-cycle pulse when a frame is dropped.
- `err_code` output, 2 bits: 0 = bad magic, 1 = unknown command, 2 = bad length, 3 = lower-layer error.
- `err_cnt` output, 8 bits: count of dropped frames. Only meaningful with the configuration macro; see Configuration.

## Operation
- Frame layout: `magic[7:0]`, `magic[15:8]`, `magic[23:16]`, `magic[31:24]`, `cmd`, then the arguments.
- Required argument counts:
  - IDENTIFY, GET_RESULT and ABORT: 0.
  - SET_SIGNAL: 4 — sync LSB, sync MSB, mask, value.
  - AUTO_READ: 10 — sync (2 bytes), timing1 (4 bytes, LSB first), timing2 (4 bytes, LSB first).
- AUTO_READ timing bytes: only bit 0 of byte 3 of each timing field is used; bits 7:1 are ignored.
- States:
  - MAGIC: byte index 0–3, compared against `MAGIC` byte by byte. A mismatch sets the bad-magic flag and moves to DROP.
  - CMD: latches `cmd`. An unknown code sets the unknown-command flag and moves to DROP. Otherwise moves to ARGS, or to DONE-check if the command takes 0 arguments.
  - ARGS: a 4-bit counter shifts bytes into the field registers. Receiving more bytes than the command allows sets the bad-length flag and moves to DROP.
  - DROP: consumes bytes until `in_last`.
- End of frame: evaluated on the `in_last` beat in any state.
  - Error priority: `in_error` > bad magic > unknown command > bad length. A frame shorter than 5 bytes, or with too few arguments, counts as bad length.
  - If no error: `req_valid` pulses.
  - Otherwise: `err_valid` pulses with the winning `err_code`.
  - Exactly one of `req_valid` or `err_valid` pulses per frame.
  - The state returns to MAGIC with the index cleared.
- Field updates: `req_*` fields update only together with `req_valid` and hold their values until the next `req_valid`. Unused fields of a command are cleared to 0 when its `req_valid` fires.
- Gaps: `in_valid` low cycles between bytes are allowed and do not affect state.
- Back-to-back frames: a new frame may start on the cycle immediately after the `in_last` beat.

## Timing
- Latency: `req_valid` and `err_valid` assert exactly 1 cycle after the `in_last` beat. All outputs are registered.
- Throughput: sustains 1 byte per cycle with no stalls.
- Reset values: all outputs 0; state is MAGIC, index 0.
- Mid-frame reset: the partial frame is discarded and no pulse is emitted.
- Post-reset: bytes arriving before the next `in_last` are parsed as a fresh frame starting with magic byte 0.

## Configuration
- Macro: `PROTOCOL_DECODER_ERR_COUNT_EN`.
- When defined: `err_cnt` increments on every `err_valid`, is updated in the same cycle as the pulse, and saturates at 255. It is cleared only by reset.
- When undefined: `err_cnt` is tied to 0 and no counter logic is synthesized.

## Test plan
- SET_SIGNAL: send `MAGIC` (LE), `Command_SET_SIGNAL`, `34 12 0F 05` with `in_last` on the last byte. Required: `req_valid` 1 cycle later, `req_sync` = 16'h1234, `req_mask` = 8'h0F, `req_value` = 8'h05.
- AUTO_READ with gaps: send `MAGIC`, `Command_AUTO_READ`, `01 00 | 78 56 34 FF | 00 00 00 00` with random `in_valid` gaps. Required: `req_sync` = 1, `req_timing1` = 25'h1345678 (upper bits of byte 3 ignored), `req_timing2` = 0.
- Bad magic: `MAGIC ^ 32'h1`, then 6 random bytes. Required: `err_valid` with `err_code` = 0, no `req_valid`, and `err_cnt` = 1 when the macro is defined.
- Length errors: IDENTIFY with 1 extra byte → `err_code` = 2. SET_SIGNAL with 3 argument bytes → `err_code` = 2. Frame of 3 bytes → `err_code` = 2.
- Unknown command and error priority: cmd 8'hEE → `err_code` = 1. A valid GET_RESULT frame with `in_error` = 1 on the last beat → `err_code` = 3.
- Back-to-back and reset: two IDENTIFY frames with zero gap → two `req_valid` pulses 5 cycles apart. Assert `rst_n` after byte 2 of a frame, then send a full ABORT frame → outputs held at 0 during reset, then exactly one `req_valid` with `req_cmd` = `Command_ABORT`.

Source files
------------

// File: rtl/protocol_request_decoder.sv
// protocol_request_decoder: parses magic/cmd/args frames into one request or error pulse per frame; PROTOCOL_DECODER_ERR_COUNT_EN adds a dropped-frame counter.
package protocol_pkg;
    localparam logic [31:0] PROTOCOL_MAGIC     = 32'hC0DE_5AA5;
    localparam logic [7:0]  Command_IDENTIFY   = 8'h01;
    localparam logic [7:0]  Command_SET_SIGNAL = 8'h02;
    localparam logic [7:0]  Command_AUTO_READ  = 8'h03;
    localparam logic [7:0]  Command_GET_RESULT = 8'h04;
    localparam logic [7:0]  Command_ABORT      = 8'h05;
endpackage

module protocol_request_decoder #(
    parameter logic [31:0] MAGIC = protocol_pkg::PROTOCOL_MAGIC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_error,
    output logic        req_valid,
    output logic [7:0]  req_cmd,
    output logic [15:0] req_sync,
    output logic [7:0]  req_mask,
    output logic [7:0]  req_value,
    output logic [24:0] req_timing1,
    output logic [24:0] req_timing2,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [7:0]  err_cnt
);
    import protocol_pkg::*;

    localparam logic [1:0] S_MAGIC = 2'd0;
    localparam logic [1:0] S_CMD   = 2'd1;
    localparam logic [1:0] S_ARGS  = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]  state_q, state_d, idx_q, idx_d, err_code_q, err_code_d;
    logic [3:0]  cnt_q, cnt_d, need;
    logic [7:0]  cmd_q, cmd_d, cur_cmd, magic_byte;
    logic [7:0]  req_cmd_q, req_cmd_d, req_mask_q, req_mask_d, req_value_q, req_value_d;
    logic [15:0] sync_s_q, sync_s_d, req_sync_q, req_sync_d;
    logic [24:0] t1_s_q, t1_s_d, t2_s_q, t2_s_d;
    logic [24:0] req_t1_q, req_t1_d, req_t2_q, req_t2_d;
    logic        magic_err_q, magic_err_d, cmd_err_q, cmd_err_d, len_err_q, len_err_d;
    logic        req_valid_q, req_valid_d, err_valid_q, err_valid_d;
    logic        known, magic_bad, extra, complete, ok;

    // Per-beat parse: advance the frame state, stage argument bytes, and resolve the frame on in_last
    always_comb begin
        cur_cmd     = (state_q == S_CMD) ? in_data : cmd_q;
        known       = cur_cmd inside {Command_IDENTIFY, Command_SET_SIGNAL, Command_AUTO_READ,
                                      Command_GET_RESULT, Command_ABORT};
        need        = (cur_cmd == Command_SET_SIGNAL) ? 4'd4 : (cur_cmd == Command_AUTO_READ) ? 4'd10 : 4'd0;
        magic_byte  = 8'(MAGIC >> {idx_q, 3'b000});
        magic_bad   = state_q == S_MAGIC && in_data != magic_byte;
        extra       = state_q == S_ARGS && cnt_q == need;
        complete    = (state_q == S_CMD && known && need == 4'd0) ||
                      (state_q == S_ARGS && !extra && cnt_q + 4'd1 == need);
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        magic_err_d = magic_err_q;
        cmd_err_d   = cmd_err_q;
        len_err_d   = len_err_q;
        sync_s_d    = sync_s_q;
        t1_s_d      = t1_s_q;
        t2_s_d      = t2_s_q;
        req_valid_d = 1'b0;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        req_cmd_d   = req_cmd_q;
        req_sync_d  = req_sync_q;
        req_mask_d  = req_mask_q;
        req_value_d = req_value_q;
        req_t1_d    = req_t1_q;
        req_t2_d    = req_t2_q;
        ok          = 1'b0;
        if (in_valid) begin
            magic_err_d = magic_err_q | magic_bad;
            cmd_err_d   = cmd_err_q | (state_q == S_CMD && !known);
            len_err_d   = len_err_q | extra;
            if (state_q == S_MAGIC) begin
                idx_d   = idx_q + 2'd1;
                state_d = magic_bad ? S_DROP : (idx_q == 2'd3) ? S_CMD : S_MAGIC;
            end else if (state_q == S_CMD) begin
                cmd_d   = in_data;
                cnt_d   = 4'd0;
                state_d = known ? S_ARGS : S_DROP;
            end else if (state_q == S_ARGS) begin
                cnt_d   = cnt_q + 4'd1;
                state_d = extra ? S_DROP : S_ARGS;
                case (cnt_q)
                    4'd0: sync_s_d[7:0]   = in_data;
                    4'd1: sync_s_d[15:8]  = in_data;
                    4'd2: t1_s_d[7:0]     = in_data;
                    4'd3: t1_s_d[15:8]    = in_data;
                    4'd4: t1_s_d[23:16]   = in_data;
                    4'd5: t1_s_d[24]      = in_data[0];
                    4'd6: t2_s_d[7:0]     = in_data;
                    4'd7: t2_s_d[15:8]    = in_data;
                    4'd8: t2_s_d[23:16]   = in_data;
                    4'd9: t2_s_d[24]      = in_data[0];
                    default: ;
                endcase
            end
            if (in_last) begin
                ok          = !in_error && !magic_err_d && !cmd_err_d && !len_err_d && complete;
                req_valid_d = ok;
                err_valid_d = !ok;
                err_code_d  = ok ? err_code_q : in_error ? 2'd3 : magic_err_d ? 2'd0 : cmd_err_d ? 2'd1 : 2'd2;
                if (ok) begin
                    req_cmd_d   = cur_cmd;
                    req_sync_d  = (cur_cmd == Command_SET_SIGNAL || cur_cmd == Command_AUTO_READ) ? sync_s_d : 16'd0;
                    req_mask_d  = (cur_cmd == Command_SET_SIGNAL) ? t1_s_d[7:0] : 8'd0;
                    req_value_d = (cur_cmd == Command_SET_SIGNAL) ? t1_s_d[15:8] : 8'd0;
                    req_t1_d    = (cur_cmd == Command_AUTO_READ) ? t1_s_d : 25'd0;
                    req_t2_d    = (cur_cmd == Command_AUTO_READ) ? t2_s_d : 25'd0;
                end
                state_d     = S_MAGIC;
                idx_d       = 2'd0;
                cnt_d       = 4'd0;
                magic_err_d = 1'b0;
                cmd_err_d   = 1'b0;
                len_err_d   = 1'b0;
            end
        end
    end

    // Parser state and registered outputs; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_MAGIC;
            idx_q       <= 2'd0;
            cnt_q       <= 4'd0;
            cmd_q       <= 8'd0;
            magic_err_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            sync_s_q    <= 16'd0;
            t1_s_q      <= 25'd0;
            t2_s_q      <= 25'd0;
            req_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
            req_cmd_q   <= 8'd0;
            req_sync_q  <= 16'd0;
            req_mask_q  <= 8'd0;
            req_value_q <= 8'd0;
            req_t1_q    <= 25'd0;
            req_t2_q    <= 25'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            magic_err_q <= magic_err_d;
            cmd_err_q   <= cmd_err_d;
            len_err_q   <= len_err_d;
            sync_s_q    <= sync_s_d;
            t1_s_q      <= t1_s_d;
            t2_s_q      <= t2_s_d;
            req_valid_q <= req_valid_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            req_cmd_q   <= req_cmd_d;
            req_sync_q  <= req_sync_d;
            req_mask_q  <= req_mask_d;
            req_value_q <= req_value_d;
            req_t1_q    <= req_t1_d;
            req_t2_q    <= req_t2_d;
        end
    end

    assign req_valid   = req_valid_q;
    assign req_cmd     = req_cmd_q;
    assign req_sync    = req_sync_q;
    assign req_mask    = req_mask_q;
    assign req_value   = req_value_q;
    assign req_timing1 = req_t1_q;
    assign req_timing2 = req_t2_q;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;

`ifdef PROTOCOL_DECODER_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating dropped-frame count, moving together with the err_valid pulse
    always_comb err_cnt_d = (err_valid_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

    // Counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'd0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif
endmodule
